// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_e;

    // addi x0, x0, 0 -- handed to fetch when the memory never answers
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data-memory requests onto one single-port
// memory, with a watchdog that turns a hung access into a NOP/zero response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    output logic                     if_ack,
    input  logic                     dm_req,
    input  logic                     dm_we,
    input  logic [ADDRESS_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0]    dm_wdata,
    output logic [DATA_WIDTH-1:0]    dm_rdata,
    output logic                     dm_ack,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack,
    output logic                     stall_if,
    output logic                     stall_mem,
    output logic                     bus_err
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    arb_state_e               state_q;
    arb_gnt_e                 gnt_q;
    arb_gnt_e                 gnt_d;
    logic [TIMER_W-1:0]       timer_q;
    logic                     mem_req_q;
    logic                     mem_we_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]    mem_wdata_q;
    logic [DATA_WIDTH-1:0]    if_rdata_q;
    logic [DATA_WIDTH-1:0]    dm_rdata_q;
    logic                     if_ack_q;
    logic                     dm_ack_q;
    logic                     bus_err_q;

    // Data normally wins; after a data grant a waiting fetch goes first.
    always_comb begin
        gnt_d = GNT_IF;
        if (dm_req && !(if_req && gnt_q == GNT_DM)) begin
            gnt_d = GNT_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            timer_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_req || dm_req) begin
                        gnt_q     <= gnt_d;
                        mem_req_q <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= BUSY;
                        if (gnt_d == GNT_DM) begin
                            mem_we_q    <= dm_we;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    // An ack on the expiry cycle still wins over the timeout.
                    if (mem_ack) begin
                        if (gnt_q == GNT_DM) begin
                            dm_rdata_q <= mem_rdata;
                            dm_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_ack_q   <= 1'b1;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                    end else if (timer_q == TIMER_LAST) begin
                        if (gnt_q == GNT_DM) begin
                            dm_rdata_q <= '0;
                            dm_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= DATA_WIDTH'(NOP_INSN);
                            if_ack_q   <= 1'b1;
                        end
                        bus_err_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                RESP: begin
                    if_ack_q  <= 1'b0;
                    dm_ack_q  <= 1'b0;
                    timer_q   <= '0;
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign bus_err   = bus_err_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single accesses plus hand-written
// contention, timeout and reset sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_if;
    logic [31:0] last_dm;

    localparam logic [31:0] JUNK = 32'hBAD0_0000;

    mem_arbiter #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] mdata;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Runs one access starting in an IDLE cycle; returns in the following IDLE cycle.
    task automatic do_txn(input vec_t v, input string tag);
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        tick();
        for (int w = 0; w <= v.waits; w++) begin
            chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, " mem_addr"}, mem_addr, v.addr);
            chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, v.exp_we});
            if (v.exp_we) chk({tag, " mem_wdata"}, mem_wdata, v.wdata);
            chk({tag, " ack_busy"}, {30'd0, if_ack, dm_ack}, 32'd0);
            chk({tag, " stall_busy"}, {31'd0, v.is_dm ? stall_mem : stall_if}, 32'd1);
            if (w == v.waits) begin
                mem_ack = 1'b1; mem_rdata = v.mdata;
            end
            tick();
        end
        mem_ack = 1'b0; mem_rdata = JUNK;
        chk({tag, " mem_req_resp"}, {31'd0, mem_req}, 32'd0);
        if (v.is_dm) begin
            chk({tag, " dm_ack"}, {30'd0, if_ack, dm_ack}, 32'd1);
            chk({tag, " dm_rdata"}, dm_rdata, v.exp_rdata);
            chk({tag, " if_rdata_hold"}, if_rdata, last_if);
            chk({tag, " stall_mem_resp"}, {31'd0, stall_mem}, 32'd0);
            last_dm = v.exp_rdata;
            dm_req = 1'b0; dm_we = 1'b0;
        end else begin
            chk({tag, " if_ack"}, {30'd0, if_ack, dm_ack}, 32'd2);
            chk({tag, " if_rdata"}, if_rdata, v.exp_rdata);
            chk({tag, " dm_rdata_hold"}, dm_rdata, last_dm);
            chk({tag, " stall_if_resp"}, {31'd0, stall_if}, 32'd0);
            last_if = v.exp_rdata;
            if_req = 1'b0;
        end
        tick();
        chk({tag, " ack_after"}, {30'd0, if_ack, dm_ack}, 32'd0);
        chk({tag, " rdata_hold"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
    endtask

    initial begin
        //            is_dm we   addr           wdata          waits mdata          exp_we exp_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        0,  32'h0050_0093, 1'b0, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        1,  32'h0000_0007, 1'b0, 32'h0000_0007};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEADBEEF, 3,  32'h1234_5678, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,        2,  32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        15, 32'h0000_A5A5, 1'b0, 32'h0000_A5A5};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0800, 32'h0,        14, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE};

        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = JUNK; mem_ack = 1'b0;
        last_if = '0; last_dm = '0;
        tick();
        tick();
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("rst if_rdata", if_rdata, 32'd0);
        chk("rst dm_rdata", dm_rdata, 32'd0);
        chk("rst bus_err", {31'd0, bus_err}, 32'd0);
        rst = 1'b0;

        // Contention with last grant = fetch: data first, then round-robin to fetch.
        if_req = 1'b1; if_addr = 32'h4;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        tick();
        chk("cont1 mem_addr", mem_addr, 32'h100);
        chk("cont1 stalls", {30'd0, stall_if, stall_mem}, 32'd3);
        mem_ack = 1'b1; mem_rdata = 32'd7;
        tick();
        mem_ack = 1'b0; mem_rdata = JUNK;
        chk("cont1 acks", {30'd0, if_ack, dm_ack}, 32'd1);
        chk("cont1 dm_rdata", dm_rdata, 32'd7);
        chk("cont1 stall_if", {31'd0, stall_if}, 32'd1);
        dm_addr = 32'h108;
        tick();
        chk("cont2 idle stall_if", {31'd0, stall_if}, 32'd1);
        tick();
        chk("cont2 rr mem_addr", mem_addr, 32'h4);
        chk("cont2 mem_we", {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h1357_2468;
        tick();
        mem_ack = 1'b0; mem_rdata = JUNK;
        chk("cont2 acks", {30'd0, if_ack, dm_ack}, 32'd2);
        chk("cont2 if_rdata", if_rdata, 32'h1357_2468);
        chk("cont2 dm_rdata_hold", dm_rdata, 32'd7);
        if_req = 1'b0;
        tick();
        tick();
        chk("cont3 mem_addr", mem_addr, 32'h108);
        mem_ack = 1'b1; mem_rdata = 32'd99;
        tick();
        mem_ack = 1'b0; mem_rdata = JUNK;
        chk("cont3 acks", {30'd0, if_ack, dm_ack}, 32'd1);
        chk("cont3 dm_rdata", dm_rdata, 32'd99);
        dm_req = 1'b0;
        last_if = 32'h1357_2468; last_dm = 32'd99;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end
        chk("vec bus_err", {31'd0, bus_err}, 32'd0);

        // mem_ack while idle must not produce anything.
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        tick();
        chk("stray ack mem_req", {31'd0, mem_req}, 32'd0);
        chk("stray ack acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("stray ack if_rdata", if_rdata, last_if);
        mem_ack = 1'b0; mem_rdata = JUNK;

        // Fetch timeout: 16 BUSY cycles, then NOP with sticky bus_err.
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to busy%0d", i), {29'd0, mem_req, if_ack, bus_err}, 32'd4);
            tick();
        end
        chk("to if_ack", {31'd0, if_ack}, 32'd1);
        chk("to if_rdata", if_rdata, 32'h0000_0013);
        chk("to bus_err", {31'd0, bus_err}, 32'd1);
        chk("to mem_req", {31'd0, mem_req}, 32'd0);
        last_if = 32'h0000_0013;
        if_req = 1'b0;
        tick();
        do_txn(vecs[1], "post_to");
        chk("to sticky", {31'd0, bus_err}, 32'd1);

        // Reset in the second BUSY cycle of a load.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; dm_req = 1'b0;
        chk("mid rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("mid rst acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("mid rst bus_err", {31'd0, bus_err}, 32'd0);
        chk("mid rst mem_addr", mem_addr, 32'd0);
        chk("mid rst dm_rdata", dm_rdata, 32'd0);
        tick();
        chk("mid rst no ack", {30'd0, if_ack, dm_ack}, 32'd0);
        last_if = '0; last_dm = '0;
        do_txn(vecs[2], "post_rst");
        do_txn(vecs[0], "post_rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
